// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: input sync/debounce, run/pause FSM, tick prescaler
// and adjust-mode blink strobes for the counter and display logic.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_rst,
  input  logic i_btn_pse,
  input  logic i_sw_sel,
  input  logic i_sw_adj,
  output logic o_cnt_tick,
  output logic o_cnt_clr,
  output logic o_pse,
  output logic o_adj,
  output logic o_sel,
  output logic o_blank_sec,
  output logic o_blank_min
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [PW-1:0] P_HALF  = PW'(TICK_DIV / 2 - 1);
  localparam logic [PW-1:0] P_FULL  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  // synchroniser bit order: {adj, sel, pse button, clear button}
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_d;
  logic [DW-1:0] r_db_cnt [2];
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_blink;
  logic          r_tick;
  logic          r_clr;

  logic [1:0] w_press;
  logic       w_clr_press;
  logic       w_pse_press;
  logic       w_adj_chg;
  logic       w_run_next;
  logic       w_load;
  logic       w_adv;
  logic       w_at_full;
  logic       w_at_half;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1 <= {i_sw_adj, i_sw_sel, i_btn_pse, i_btn_rst};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          r_deb[b]    <= r_sync2[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_press     = r_deb & ~r_deb_d;
  assign w_clr_press = w_press[0];
  assign w_pse_press = w_press[1];
  assign w_adj_chg   = r_sync1[3] ^ r_sync2[3];

  // clear overrides pause; a press that pauses also freezes the prescaler this edge
  assign w_run_next = w_clr_press ||
                      (r_state == ST_RUN ? !w_pse_press : w_pse_press);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:    if (!w_clr_press && w_pse_press) r_state <= ST_PAUSED;
        ST_PAUSED: if (w_clr_press || w_pse_press)  r_state <= ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  assign w_load    = w_clr_press | w_adj_chg;
  assign w_adv     = w_run_next & ~w_load;
  assign w_at_full = (r_presc == P_FULL);
  assign w_at_half = (r_presc == P_HALF) | w_at_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_blink <= 1'b0;
      r_tick  <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_clr <= w_clr_press;
      if (w_load) begin
        r_presc <= '0;
        r_blink <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_tick <= w_adv & (r_sync2[3] ? w_at_half : w_at_full);
        if (w_adv) begin
          r_presc <= w_at_full ? '0 : r_presc + 1'b1;
          if (w_at_half) r_blink <= ~r_blink;
        end
      end
    end
  end

  assign o_cnt_tick  = r_tick;
  assign o_cnt_clr   = r_clr;
  assign o_pse       = (r_state == ST_PAUSED);
  assign o_adj       = r_sync2[3];
  assign o_sel       = r_sync2[2];
  assign o_blank_sec = r_sync2[3] & r_sync2[2] & r_blink;
  assign o_blank_min = r_sync2[3] & ~r_sync2[2] & r_blink;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, timed corner-case sequences and
// randomized traffic, all compared with a cycle-level behavioural model.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int DB_CYCLES = 4;

  logic clk = 1'b0;
  logic rst, btn_rst, btn_pse, sw_sel, sw_adj;
  logic cnt_tick, cnt_clr, pse, adj, sel, blank_sec, blank_min;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_rst(btn_rst), .i_btn_pse(btn_pse),
    .i_sw_sel(sw_sel), .i_sw_adj(sw_adj),
    .o_cnt_tick(cnt_tick), .o_cnt_clr(cnt_clr), .o_pse(pse), .o_adj(adj),
    .o_sel(sel), .o_blank_sec(blank_sec), .o_blank_min(blank_min)
  );

  always #5 clk = ~clk;

  // reference model: raw input history, stability run lengths, elapsed time
  bit [3:0] m_s1, m_s2;
  bit [1:0] m_deb, m_pend;
  int       m_run [2];
  int       m_phase, m_halfs;
  bit       m_pse, m_tick, m_clr;

  function automatic logic [6:0] actual();
    return {cnt_tick, cnt_clr, pse, adj, sel, blank_sec, blank_min};
  endfunction

  function automatic logic [6:0] model_out();
    bit b;
    b = m_halfs[0];
    return {m_tick, m_clr, m_pse, m_s2[3], m_s2[2],
            m_s2[3] & m_s2[2] & b, m_s2[3] & ~m_s2[2] & b};
  endfunction

  task automatic model_edge();
    bit pc, pp, new_pse, load;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_phase = 0; m_halfs = 0; m_pse = 0; m_tick = 0; m_clr = 0;
      return;
    end
    pc      = m_pend[0];
    pp      = m_pend[1];
    new_pse = pc ? 1'b0 : (pp ? !m_pse : m_pse);
    load    = pc || (m_s1[3] != m_s2[3]);
    m_clr   = pc;
    if (load) begin
      m_phase = 0; m_halfs = 0; m_tick = 0;
    end else if (!new_pse) begin
      m_phase = (m_phase + 1) % TICK_DIV;
      m_tick  = m_s2[3] ? (m_phase % (TICK_DIV / 2) == 0) : (m_phase == 0);
      if (m_phase % (TICK_DIV / 2) == 0) m_halfs++;
    end else begin
      m_tick = 0;
    end
    m_pse = new_pse;
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 0;
      if (m_s2[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DB_CYCLES) begin
          m_deb[b]  = m_s2[b];
          m_run[b]  = 0;
          m_pend[b] = m_deb[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {sw_adj, sw_sel, btn_pse, btn_rst};
  endtask

  task automatic chk(input string nm, input int n, input logic [6:0] act,
                     input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", 0, actual(), model_out());
  endtask

  task automatic drive(input bit r, input bit br, input bit bp, input bit s, input bit a);
    rst = r; btn_rst = br; btn_pse = bp; sw_sel = s; sw_adj = a;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    step();
    step();
    rst = 0;
  endtask

  typedef struct {
    bit r, br, bp, s, a;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [$];
  int   clr_cnt;
  int   hold_r, hold_p;
  int   n;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // reset with buttons/switches high, then release and watch sel latency and ticks
    for (int k = 0; k < 3; k++) begin
      v.r = 1; v.br = 0; v.bp = 1; v.s = 1; v.a = 1; v.exp = '0;
      vecs.push_back(v);
    end
    for (int c = 0; c <= 20; c++) begin
      v.r = 0; v.br = 0; v.bp = 0; v.s = 1; v.a = 0;
      v.exp = '0;
      v.exp[6] = (c + 1 == 10) || (c + 1 == 20);
      v.exp[2] = (c + 1 >= 2);
      vecs.push_back(v);
    end

    drive(1, 0, 0, 0, 0);
    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].br, vecs[k].bp, vecs[k].s, vecs[k].a);
      step();
      chk("vector", k, actual(), vecs[k].exp);
    end

    // pause/resume: frozen prescaler resumes, the held tick comes out on resume
    do_reset();
    for (int c = 0; c < 60; c++) begin
      btn_pse = (c >= 13 && c <= 25) || (c >= 40 && c <= 50);
      step();
      n = c + 1;
      chk("pause_pse", n, 7'(pse), 7'(n >= 20 && n < 47));
      chk("pause_tick", n, 7'(cnt_tick), 7'(n == 10 || n == 47 || n == 57));
    end

    // clear while paused, button held 100 cycles
    do_reset();
    clr_cnt = 0;
    for (int c = 0; c < 130; c++) begin
      btn_pse = (c < 10);
      btn_rst = (c >= 20 && c < 120);
      step();
      n = c + 1;
      clr_cnt += int'(cnt_clr);
      chk("clear_clr", n, 7'(cnt_clr), 7'(n == 27));
      chk("clear_pse", n, 7'(pse), 7'(n >= 7 && n < 27));
      chk("clear_tick", n, 7'(cnt_tick), 7'(n >= 37 && (n - 37) % 10 == 0));
    end
    chk("clear_pulses", 130, 7'(clr_cnt), 7'd1);

    // both buttons together while running: clear wins, stays RUN
    do_reset();
    clr_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      btn_pse = (c >= 5 && c < 15);
      btn_rst = (c >= 5 && c < 15);
      step();
      n = c + 1;
      clr_cnt += int'(cnt_clr);
      chk("both_pse", n, 7'(pse), 7'd0);
      chk("both_clr", n, 7'(cnt_clr), 7'(n == 12));
    end
    chk("both_pulses", 40, 7'(clr_cnt), 7'd1);

    // reset in the middle of a clear-button debounce
    do_reset();
    for (int c = 0; c < 50; c++) begin
      btn_pse = (c < 10);
      btn_rst = (c >= 20 && c < 25);
      rst     = (c == 25);
      step();
      n = c + 1;
      chk("rstmid_clr", n, 7'(cnt_clr), 7'd0);
      chk("rstmid_pse", n, 7'(pse), 7'(n >= 7 && n < 26));
      chk("rstmid_tick", n, 7'(cnt_tick), 7'(n >= 36 && (n - 36) % 10 == 0));
      if (n == 26) chk("rstmid_all", n, actual(), 7'd0);
    end

    // bouncing pause button and a 3-cycle glitch
    do_reset();
    for (int c = 0; c < 50; c++) begin
      btn_pse = (c < 20) ? ((c / 2) % 2 == 0) : (c >= 30 && c < 33);
      step();
      n = c + 1;
      chk("bounce_pse", n, 7'(pse), 7'd0);
      chk("bounce_clr", n, 7'(cnt_clr), 7'd0);
      chk("bounce_tick", n, 7'(cnt_tick), 7'(n % 10 == 0));
    end

    // adjust mode: half-rate ticks and flashing field, then switch field
    do_reset();
    for (int c = 0; c < 35; c++) begin
      sw_adj = 1;
      sw_sel = (c < 20);
      step();
      n = c + 1;
      chk("adj_adj", n, 7'(adj), 7'(n >= 2));
      chk("adj_sel", n, 7'(sel), 7'(n >= 2 && n < 22));
      chk("adj_tick", n, 7'(cnt_tick), 7'(n >= 7 && (n - 7) % 5 == 0));
      chk("adj_bsec", n, 7'(blank_sec), 7'(n >= 7 && n < 22 && ((n - 7) / 5) % 2 == 0));
      chk("adj_bmin", n, 7'(blank_min), 7'(n >= 22 && ((n - 7) / 5) % 2 == 0));
    end

    // randomized traffic against the model only
    do_reset();
    hold_r = 0;
    hold_p = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold_r == 0) begin
        btn_rst = ($urandom_range(0, 3) == 0);
        hold_r  = $urandom_range(1, 12);
      end
      if (hold_p == 0) begin
        btn_pse = ($urandom_range(0, 1) == 0);
        hold_p  = $urandom_range(1, 12);
      end
      hold_r--;
      hold_p--;
      if ($urandom_range(0, 49) == 0) sw_adj = ~sw_adj;
      if ($urandom_range(0, 29) == 0) sw_sel = ~sw_sel;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
